// File: rtl/adc_safety_monitor.sv
// ADC safety monitor: checks that every laser pulse is answered by one well-formed,
// in-window ADC sample before a timeout, and latches a fault that drops the laser permit.
module adc_safety_monitor #(
  parameter int MAX_CONSEC     = 3,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        laser_pulse,
  input  logic        adc_data_valid,
  input  logic [15:0] adc_data_value,
  input  logic [11:0] thr_low,
  input  logic [11:0] thr_high,
  input  logic        fault_clear,
  output logic        laser_enable,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [11:0] last_sample,
  output logic [15:0] sample_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_EVAL  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_LOW      = 3'd1;
  localparam logic [2:0] CODE_HIGH     = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT  = 3'd3;
  localparam logic [2:0] CODE_FORMAT   = 3'd4;
  localparam logic [2:0] CODE_SPURIOUS = 3'd5;

  localparam logic [3:0]  MAX_C        = 4'(MAX_CONSEC);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_laser_pulse_d;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic [11:0] r_sample;
  logic [11:0] w_sample_nxt;
  logic [3:0]  r_consec;
  logic [3:0]  w_consec_nxt;
  logic [2:0]  w_cause;

  logic        r_laser_enable;
  logic        r_fault;
  logic [2:0]  r_fault_code;
  logic [11:0] r_last_sample;
  logic [15:0] r_sample_count;

  logic        w_laser_enable_nxt;
  logic        w_fault_nxt;
  logic [2:0]  w_fault_code_nxt;
  logic [11:0] w_last_sample_nxt;
  logic [15:0] w_sample_count_nxt;

  logic        w_rise;
  logic        w_low;
  logic        w_high;

  assign w_rise = laser_pulse & ~r_laser_pulse_d;
  // LOW is tested first, so an inverted window (thr_low > thr_high) rejects every code.
  assign w_low  = (r_sample < thr_low);
  assign w_high = ~w_low & (r_sample > thr_high);

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_laser_pulse_d <= 1'b0;
      r_timer         <= 16'd0;
      r_sample        <= 12'd0;
      r_consec        <= 4'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_laser_pulse_d <= laser_pulse;
      r_timer         <= w_timer_nxt;
      r_sample        <= w_sample_nxt;
      r_consec        <= w_consec_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = 16'd0;
    w_sample_nxt = r_sample;
    w_consec_nxt = r_consec;
    w_cause      = CODE_NONE;
    unique case (r_state)
      S_IDLE: begin
        if (adc_data_valid) begin
          w_state_nxt = S_FAULT;
          w_cause     = CODE_SPURIOUS;
        end else if (w_rise) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (adc_data_valid) begin
          if (adc_data_value[15:12] != 4'd0) begin
            w_state_nxt = S_FAULT;
            w_cause     = CODE_FORMAT;
          end else begin
            w_sample_nxt = adc_data_value[11:0];
            w_state_nxt  = S_EVAL;
          end
        end else if (r_timer == TIMEOUT_LAST) begin
          w_state_nxt = S_FAULT;
          w_cause     = CODE_TIMEOUT;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_EVAL: begin
        if (w_low || w_high) begin
          w_consec_nxt = r_consec + 4'd1;
        end else begin
          w_consec_nxt = 4'd0;
        end
        if (w_consec_nxt >= MAX_C) begin
          w_state_nxt = S_FAULT;
          w_cause     = w_low ? CODE_LOW : CODE_HIGH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        // A clear is only honoured while the laser request is low.
        if (fault_clear && !laser_pulse) begin
          w_state_nxt  = S_IDLE;
          w_consec_nxt = 4'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computed from the next state so outputs change on the same
  // edge the state does.
  always_comb begin
    w_laser_enable_nxt = (w_state_nxt != S_FAULT);
    w_fault_nxt        = (w_state_nxt == S_FAULT);
    w_fault_code_nxt   = CODE_NONE;
    if (w_state_nxt == S_FAULT) begin
      w_fault_code_nxt = (r_state == S_FAULT) ? r_fault_code : w_cause;
    end
    w_last_sample_nxt  = r_last_sample;
    w_sample_count_nxt = r_sample_count;
    if (r_state == S_EVAL) begin
      w_last_sample_nxt = r_sample;
      if (r_sample_count != 16'hFFFF) begin
        w_sample_count_nxt = r_sample_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_laser_enable <= 1'b0;
      r_fault        <= 1'b0;
      r_fault_code   <= CODE_NONE;
      r_last_sample  <= 12'd0;
      r_sample_count <= 16'd0;
    end else begin
      r_laser_enable <= w_laser_enable_nxt;
      r_fault        <= w_fault_nxt;
      r_fault_code   <= w_fault_code_nxt;
      r_last_sample  <= w_last_sample_nxt;
      r_sample_count <= w_sample_count_nxt;
    end
  end

  assign laser_enable = r_laser_enable;
  assign fault        = r_fault;
  assign fault_code   = r_fault_code;
  assign last_sample  = r_last_sample;
  assign sample_count = r_sample_count;

endmodule

// File: doc/adc_safety_monitor.md
ADC_SAFETY_MONITOR -- requirements
Module: adc_safety_monitor

Interface
REQ-001 SHALL have parameter MAX_CONSEC, default 3, meaning consecutive out-of-window samples that trip a fault (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200, meaning clk cycles allowed from laser_pulse rise to adc_data_valid (legal range 2..65535).
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port laser_pulse  in  1  laser fire request, the same signal the ADC sequencer sees.
REQ-006 SHALL have port adc_data_valid  in  1  one-cycle strobe from the ADC sequencer.
REQ-007 SHALL have port adc_data_value  in  16  {4'h0, 12-bit ADC code}.
REQ-008 SHALL have ports thr_low, thr_high  in  12 each  inclusive acceptance window.
REQ-009 SHALL have port fault_clear  in  1  request to leave FAULT.
REQ-010 SHALL have port laser_enable  out  1  registered permit to the laser driver.
REQ-011 SHALL have port fault  out  1  registered latched fault.
REQ-012 SHALL have port fault_code  out  3  fault cause: 0 none, 1 LOW, 2 HIGH, 3 TIMEOUT, 4 FORMAT, 5 SPURIOUS.
REQ-013 SHALL have port last_sample  out  12  most recently accepted code.
REQ-014 SHALL have port sample_count  out  16  count of evaluated samples; saturates at 16'hFFFF.

Function
REQ-015 SHALL detect rise = laser_pulse & ~laser_pulse_d, where laser_pulse_d is a register reset to 0.
REQ-016 SHALL implement states IDLE, WAIT, EVAL and FAULT.
REQ-017 IDLE: on rise, go to WAIT with timer=0; on adc_data_valid, go to FAULT with code 5 (if rise and valid coincide, the valid check wins).
REQ-018 WAIT: on adc_data_valid, if adc_data_value[15:12]!=0 go to FAULT with code 4, else capture [11:0] into sample_reg and go to EVAL.
REQ-019 WAIT: if no valid and timer==TIMEOUT_CYCLES-1, go to FAULT with code 3; otherwise increment timer; valid wins over timeout in the same cycle.
REQ-020 WAIT/EVAL: further laser_pulse rises SHALL be ignored (no re-arm, no fault).
REQ-021 EVAL (one cycle): last_sample<=sample_reg; sample_count increments (saturating); thresholds are sampled in this cycle.
REQ-022 EVAL, sample<thr_low: consec+1; sample>thr_high: consec+1; sample in window: consec<=0; then go to IDLE.
REQ-023 EVAL: if the new consec >= MAX_CONSEC, go to FAULT with code 1 (low) or 2 (high) instead of IDLE.
REQ-024 thr_low>thr_high SHALL make every sample a violation; the LOW test has priority.
REQ-025 FAULT/laser outputs: fault<=1, laser_enable<=0 and fault_code<=cause on the same edge the state enters FAULT.
REQ-026 Outside FAULT: laser_enable<=1 and fault<=0.
REQ-027 FAULT: hold outputs; on fault_clear=1 with laser_pulse=0, go to IDLE, clear fault_code, clear consec, and set laser_enable the same edge.
REQ-028 FAULT: fault_clear while laser_pulse=1 SHALL be ignored; fault_clear in any other state SHALL have no effect.
REQ-029 sample_count and last_sample SHALL NOT be cleared by fault_clear.

Reset
REQ-030 rstn low SHALL immediately force state=IDLE, laser_enable=0, fault=0, fault_code=0, last_sample=0, sample_count=0, consec=0, timer=0, laser_pulse_d=0.
REQ-031 After reset release, laser_enable SHALL be 1 on the first clock edge; reset mid-WAIT/EVAL/FAULT discards the pending operation.

Verification (thr_low=100, thr_high=3000, defaults)
REQ-032 Reset release, no stimulus -> laser_enable 0 then 1 after one edge; all other outputs 0.
REQ-033 Pulse, valid 0x0800 after 30 cycles -> last_sample=0x800, sample_count=1, no fault.
REQ-034 Three pulses each with 0x0FA0 -> fault=1, code=2, laser_enable=0 after the third EVAL.
REQ-035 Same sequence with 0x0800 inserted before the third -> no fault.
REQ-036 Pulse, no valid -> fault with code 3 exactly 200 cycles after entering WAIT.
REQ-037 Valid 0x1800 in WAIT -> code 4; fault_clear with laser_pulse=1 ignored; fault_clear with laser_pulse=0 -> IDLE, laser_enable=1.
